param_reg_file: RTL

- Parametrised next-generation register file for the MIPS-style datapath.
- Generalised in width, depth and output-port width.
- Keeps the wide (multiply) dual write, with configurable LO/HI destination indices.
- Adds a registered I/O port with a change strobe, out-of-range address handling, and optional write-to-read bypass.
- Sits between decode (read addresses), ALU/multiplier (write data) and the external output port.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_port_reg.sv | 27 ++
 rtl/param_reg_file.sv | 98 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for param_reg_file: address-width helper,
// default LO/HI/port register indices and the write-mode encoding.
package regfile_pkg;

  localparam int DEF_LO_IDX = 0;
  localparam int DEF_HI_IDX = 3;

  typedef enum logic [1:0] {
    WM_NONE,
    WM_SINGLE,
    WM_WIDE
  } wmode_e;

  // Address width; a 1-bit address is kept even for a 1- or 2-entry file.
  function automatic int aw_of(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

  // The top register is mirrored to the output port unless overridden.
  function automatic int def_port_idx(input int num_regs);
    return num_regs - 1;
  endfunction

endpackage

// File: rtl/regfile_port_reg.sv
// Registered output port with a change strobe; port follows the value the
// mirrored register will hold after the current edge.
module regfile_port_reg
  import regfile_pkg::*;
#(
  parameter int PORT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PORT_W-1:0] nxt,
  output logic [PORT_W-1:0] port,
  output logic              port_stb
);

  // NOTE: state registers use non-blocking assignments so port_stb compares
  // nxt against the pre-edge port value, not the one being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      port     <= '0;
      port_stb <= 1'b0;
    end else begin
      port     <= nxt;
      port_stb <= (nxt != port);
    end
  end

endmodule

// File: rtl/param_reg_file.sv
// Parametrised register file with single/wide (LO/HI) writes, combinational
// reads and a registered output port. Define REGFILE_BYPASS_EN to forward
// write data to the read ports in the cycle the write commits.
module param_reg_file
  import regfile_pkg::*;
#(
  parameter int  DATA_W   = 32,
  parameter int  NUM_REGS = 8,
  parameter int  LO_IDX   = DEF_LO_IDX,
  parameter int  HI_IDX   = DEF_HI_IDX,
  parameter int  PORT_IDX = def_port_idx(NUM_REGS),
  parameter int  PORT_W   = 8,
  localparam int AW       = aw_of(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sto,
  input  logic              mul,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] din_ext,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] dout1,
  output logic [DATA_W-1:0] dout2,
  output logic [PORT_W-1:0] port,
  output logic              port_stb
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] wd   [NUM_REGS];
  logic [NUM_REGS-1:0] we;
  logic [PORT_W-1:0] port_nxt;
  wmode_e wmode;

  always_comb begin
    if (!sto)     wmode = WM_NONE;
    else if (mul) wmode = WM_WIDE;
    else          wmode = WM_SINGLE;
  end

  // Per-register write enable/data; an out-of-range waddr matches nothing.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch,
    // so no path leaves we/wd unassigned and no latch is inferred.
    we = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wd[i] = din;
      case (wmode)
        WM_SINGLE: we[i] = (waddr == AW'(i));
        WM_WIDE: begin
          if (i == LO_IDX) we[i] = 1'b1;
          if (i == HI_IDX) begin
            we[i] = 1'b1;
            wd[i] = din_ext;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the array itself is reset because every register must read back
  // as zero after rst, not just the port state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (we[i]) regs[i] <= wd[i];
    end
  end

  always_comb begin
    dout1 = '0;
    dout2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr1 == AW'(i)) dout1 = regs[i];
      if (raddr2 == AW'(i)) dout2 = regs[i];
`ifdef REGFILE_BYPASS_EN
      if (!rst && we[i] && raddr1 == AW'(i)) dout1 = wd[i];
      if (!rst && we[i] && raddr2 == AW'(i)) dout2 = wd[i];
`endif
    end
  end

  assign port_nxt = we[PORT_IDX] ? wd[PORT_IDX][PORT_W-1:0]
                                 : regs[PORT_IDX][PORT_W-1:0];

  regfile_port_reg #(.PORT_W(PORT_W)) u_port (
    .clk      (clk),
    .rst      (rst),
    .nxt      (port_nxt),
    .port     (port),
    .port_stb (port_stb)
  );

endmodule
